// File: rtl/state_mem_pkg.sv
// Shared MEM/EX stage definitions: FSM states, funct3 load/store codes, mem_info layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package state_mem_pkg;

  // MEM stage FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,   // waiting for an EX result
    REQ  = 2'd1,   // memory request presented, waiting for Mem_Req_Ready
    RDW  = 2'd2    // load issued, waiting for Read_data_Valid
  } state_t;

  // funct3 codes for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // mem_info bit layout: {funct3[2:0], store, load, strb[3:0]}
  localparam int MEM_INFO_W  = 9;
  localparam int MI_STRB_LSB = 0;
  localparam int MI_LOAD     = 4;
  localparam int MI_STORE    = 5;
  localparam int MI_F3_LSB   = 6;

  typedef struct packed {
    logic [2:0] funct3;
    logic       store;
    logic       load;
    logic [3:0] strb;
  } mem_info_t;

  function automatic mem_info_t unpack_info(input logic [MEM_INFO_W-1:0] v);
    mem_info_t r;
    r.funct3 = v[MI_F3_LSB +: 3];
    r.store  = v[MI_STORE];
    r.load   = v[MI_LOAD];
    r.strb   = v[MI_STRB_LSB +: 4];
    return r;
  endfunction

endpackage

// File: rtl/state_mem_load_extend.sv
// Load data extraction: picks byte/half/word from the read word and sign/zero extends.
// Latency: purely combinational.
// Backpressure: none.
// Ports: Read_data (raw word), addr (byte offset), funct3 (load type) -> value.
module load_extend
  import state_mem_pkg::*;
(
  input  logic [31:0] Read_data,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = Read_data[7:0];
    half_sel = Read_data[15:0];
    value    = Read_data;

    case (addr)
      2'd1:    byte_sel = Read_data[15:8];
      2'd2:    byte_sel = Read_data[23:16];
      2'd3:    byte_sel = Read_data[31:24];
      default: byte_sel = Read_data[7:0];
    endcase

    if (addr[1]) half_sel = Read_data[31:16];

    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'd0, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'd0, half_sel};
      F3_W:    value = Read_data;
      default: value = Read_data;
    endcase
  end

endmodule

// File: rtl/state_mem.sv
// MEM pipeline stage: latches EX result, performs load/store handshake, hands result to WB.
// Latency: 1 cycle for non-memory ops; memory ops take 1 + request wait (+ read wait for loads).
// Backpressure: fb_mem stalls EX while an access is outstanding; request held until Mem_Req_Ready.
// Ports: complete_pre/mem_info_in/Write_data_in/mem_address_in/RF_waddr_in/PC_input from EX;
//        Address/MemRead/MemWrite/Write_data/Write_strb/Mem_Req_Ready request channel;
//        Read_data/Read_data_Valid/Read_data_Ready read channel; RF_* and PC_output to WB.
module state_mem
  import state_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  complete_pre,
  output logic                  complete_this,
  input  logic [MEM_INFO_W-1:0] mem_info_in,
  input  logic [31:0]           Write_data_in,
  input  logic [31:0]           mem_address_in,
  input  logic [4:0]            RF_waddr_in,
  input  logic [31:0]           PC_input,
  output logic                  fb_mem,
  output logic [31:0]           Address,
  output logic                  MemWrite,
  output logic [31:0]           Write_data,
  output logic [3:0]            Write_strb,
  output logic                  MemRead,
  input  logic                  Mem_Req_Ready,
  input  logic [31:0]           Read_data,
  input  logic                  Read_data_Valid,
  output logic                  Read_data_Ready,
  output logic [4:0]            RF_waddr_out,
  output logic [31:0]           RF_wdata_out,
  output logic                  RF_wen_out,
  output logic [31:0]           PC_output
);

  state_t      state_q, state_d;
  mem_info_t   info_in, info_q;
  logic [31:0] wdata_q, addr_q, pc_q, rf_wdata_q, load_val;
  logic [4:0]  waddr_q;
  logic        complete_q;
  logic        accept, req_done, rd_done;

  assign info_in = unpack_info(mem_info_in);

  load_extend u_load_extend (
    .Read_data (Read_data),
    .addr      (addr_q[1:0]),
    .funct3    (info_q.funct3),
    .value     (load_val)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and request/handshake outputs, all from registered state
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    req_done        = 1'b0;
    rd_done         = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    Read_data_Ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (complete_pre) begin
          accept = 1'b1;
          if (info_in.load || info_in.store) state_d = REQ;
        end
      end
      REQ: begin
        // load wins if both flags are ever set, so the strobes stay exclusive
        MemRead  = info_q.load;
        MemWrite = info_q.store & ~info_q.load;
        if (Mem_Req_Ready) begin
          req_done = 1'b1;
          state_d  = info_q.load ? RDW : IDLE;
        end
      end
      RDW: begin
        Read_data_Ready = 1'b1;
        if (Read_data_Valid) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched instruction fields and WB result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      info_q     <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      pc_q       <= '0;
      waddr_q    <= '0;
      rf_wdata_q <= '0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      if (accept) begin
        info_q  <= info_in;
        wdata_q <= Write_data_in;
        addr_q  <= mem_address_in;
        pc_q    <= PC_input;
        waddr_q <= RF_waddr_in;
        if (!(info_in.load || info_in.store)) begin
          complete_q <= 1'b1;
          rf_wdata_q <= Write_data_in;
        end
      end
      if (req_done && !info_q.load) complete_q <= 1'b1;
      if (rd_done) begin
        complete_q <= 1'b1;
        rf_wdata_q <= load_val;
      end
    end
  end

  assign fb_mem        = (state_q == REQ) || (state_q == RDW);
  assign complete_this = complete_q;
  assign RF_wen_out    = complete_q & ~info_q.store & (waddr_q != 5'd0);
  assign Address       = {addr_q[31:2], 2'b00};
  assign Write_data    = wdata_q;
  assign Write_strb    = info_q.strb;
  assign RF_waddr_out  = waddr_q;
  assign RF_wdata_out  = rf_wdata_q;
  assign PC_output     = pc_q;

endmodule

// File: tb/tb_state_mem.sv
module tb_state_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        complete_pre, complete_this;
  logic [8:0]  mem_info_in;
  logic [31:0] Write_data_in, mem_address_in, PC_input;
  logic [4:0]  RF_waddr_in;
  logic        fb_mem;
  logic [31:0] Address, Write_data;
  logic        MemWrite, MemRead, Mem_Req_Ready;
  logic [3:0]  Write_strb;
  logic [31:0] Read_data;
  logic        Read_data_Valid, Read_data_Ready;
  logic [4:0]  RF_waddr_out;
  logic [31:0] RF_wdata_out, PC_output;
  logic        RF_wen_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  state_mem dut (
    .clk(clk), .rst(rst),
    .complete_pre(complete_pre), .complete_this(complete_this),
    .mem_info_in(mem_info_in), .Write_data_in(Write_data_in),
    .mem_address_in(mem_address_in), .RF_waddr_in(RF_waddr_in),
    .PC_input(PC_input), .fb_mem(fb_mem),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data),
    .Write_strb(Write_strb), .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .RF_waddr_out(RF_waddr_out), .RF_wdata_out(RF_wdata_out),
    .RF_wen_out(RF_wen_out), .PC_output(PC_output)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference load result: shift the addressed lane down, mask, then sign-adjust arithmetically
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [2:0] f3);
    longint v;
    logic [31:0] sh;
    v = longint'(rd);
    if (f3 == 3'b000 || f3 == 3'b100) begin
      sh = rd >> (8 * a);
      v = longint'(sh & 32'hFF);
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      sh = rd >> (16 * a[1]);
      v = longint'(sh & 32'hFFFF);
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // Transaction-level model: one instruction in flight, with the phase of its memory access
  bit          m_busy = 0;
  int          m_phase = 0;      // 1: waiting request accept, 2: waiting read data
  logic        m_ld, m_st;
  logic [2:0]  m_f3;
  logic [3:0]  m_strb;
  logic [31:0] m_addr, m_wd, m_pc;
  logic [4:0]  m_wa;
  bit          p_v = 0, p_wen = 0, p_store = 0;
  logic [31:0] p_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_complete_this", complete_this, 0);
      chk("rst_rf_wen", RF_wen_out, 0);
      chk("rst_memread", MemRead, 0);
      chk("rst_memwrite", MemWrite, 0);
      chk("rst_rd_ready", Read_data_Ready, 0);
      chk("rst_fb_mem", fb_mem, 0);
      chk("rst_address", Address, 0);
      chk("rst_wdata", Write_data, 0);
      chk("rst_strb", Write_strb, 0);
      chk("rst_rf_wdata", RF_wdata_out, 0);
      chk("rst_rf_waddr", RF_waddr_out, 0);
      chk("rst_pc", PC_output, 0);
      m_busy = 0; m_phase = 0; p_v = 0;
    end else begin
      chk("m_complete_this", complete_this, p_v);
      if (p_v) begin
        chk("m_rf_waddr", RF_waddr_out, m_wa);
        chk("m_pc", PC_output, m_pc);
        chk("m_rf_wen", RF_wen_out, p_wen);
        if (!p_store) chk("m_rf_wdata", RF_wdata_out, p_wdata);
      end else begin
        chk("m_rf_wen_idle", RF_wen_out, 0);
      end
      chk("m_fb_mem", fb_mem, m_busy);
      chk("m_memread", MemRead, m_busy && m_phase == 1 && m_ld);
      chk("m_memwrite", MemWrite, m_busy && m_phase == 1 && m_st);
      chk("m_rd_ready", Read_data_Ready, m_busy && m_phase == 2);
      if (m_busy && m_phase == 1) begin
        chk("m_address", Address, {m_addr[31:2], 2'b00});
        if (m_st) begin
          chk("m_wdata", Write_data, m_wd);
          chk("m_strb", Write_strb, m_strb);
        end
      end
      // advance to what the next clock edge must produce
      p_v = 0;
      if (!m_busy) begin
        if (complete_pre) begin
          {m_f3, m_st, m_ld, m_strb} = mem_info_in;
          m_addr = mem_address_in; m_wd = Write_data_in; m_pc = PC_input; m_wa = RF_waddr_in;
          if (m_ld || m_st) begin
            m_busy = 1; m_phase = 1;
          end else begin
            p_v = 1; p_wdata = m_wd; p_wen = (m_wa != 0); p_store = 0;
          end
        end
      end else if (m_phase == 1 && Mem_Req_Ready) begin
        if (m_st) begin
          m_busy = 0; p_v = 1; p_wen = 0; p_store = 1;
        end else begin
          m_phase = 2;
        end
      end else if (m_phase == 2 && Read_data_Valid) begin
        m_busy = 0; p_v = 1; p_store = 0; p_wen = (m_wa != 0);
        p_wdata = model_load(Read_data, m_addr[1:0], m_f3);
      end
    end
  end

  // Drive one instruction and observe it until its completion pulse
  task automatic run_op(input logic [2:0] f3, input logic ld, input logic st,
                        input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] wa, input int req_dly, input int dat_dly,
                        input logic [31:0] rdata,
                        output logic [31:0] res, output logic wen, output logic fb_done,
                        output int done_cyc, output int n_rd, output int n_wr, output int n_rdy,
                        output int n_fb_low, output logic [31:0] a_seen,
                        output logic [31:0] wd_seen, output logic [3:0] s_seen);
    bit done;
    done = 0; res = 0; wen = 0; fb_done = 1; done_cyc = -1;
    n_rd = 0; n_wr = 0; n_rdy = 0; n_fb_low = 0; a_seen = 0; wd_seen = 0; s_seen = 0;
    step();
    complete_pre = 1; mem_info_in = {f3, st, ld, strb};
    Write_data_in = wd; mem_address_in = addr; RF_waddr_in = wa; PC_input = addr ^ 32'h0000_4000;
    step();
    complete_pre = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      Mem_Req_Ready   = (c >= req_dly);
      Read_data_Valid = (c >= req_dly + 1 + dat_dly);
      Read_data       = rdata;
      @(negedge clk);
      if (MemRead)  begin n_rd++; a_seen = Address; end
      if (MemWrite) begin n_wr++; a_seen = Address; wd_seen = Write_data; s_seen = Write_strb; end
      if (Read_data_Ready) n_rdy++;
      if (complete_this) begin
        done = 1; res = RF_wdata_out; wen = RF_wen_out; fb_done = fb_mem; done_cyc = c;
      end else if (!fb_mem) begin
        n_fb_low++;
      end
      step();
    end
    Mem_Req_Ready = 0; Read_data_Valid = 0;
    chk("op_completed", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] res, as, ws;
    logic        wen, fbd;
    logic [3:0]  ss;
    int          dc, nr, nw, ny, nf;
    int          np;
    int          pidx[2];
    logic [31:0] pw[2];
    logic [4:0]  pa[2];
    bit          drop;

    rst = 0; complete_pre = 0; mem_info_in = 0; Write_data_in = 0; mem_address_in = 0;
    RF_waddr_in = 0; PC_input = 0; Mem_Req_Ready = 0; Read_data = 0; Read_data_Valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // ALU op: result one cycle later, written to x5
    run_op(3'b000, 0, 0, 4'h0, 32'h0, 32'h1234, 5'd5, 0, 0, 32'h0,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("alu_wdata", res, 32'h1234);
    chk("alu_wen", wen, 1);
    chk("alu_latency", dc, 0);
    chk("alu_fb_mem", fbd, 0);

    // ALU op to x0 never writes
    run_op(3'b000, 0, 0, 4'h0, 32'h0, 32'h77, 5'd0, 0, 0, 32'h0,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("alu_x0_wen", wen, 0);

    // LB from top byte, request accepted after 3 waits, data after 2 more
    run_op(3'b000, 1, 0, 4'h0, 32'h1003, 32'h0, 5'd3, 3, 2, 32'h80FF_FF7F,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("lb_wdata", res, 32'hFFFF_FF80);
    chk("lb_address", as, 32'h1000);
    chk("lb_fb_high", nf, 0);
    chk("lb_memread_cycles", nr, 4);
    chk("lb_rd_ready_cycles", ny, 3);
    chk("lb_done_cycle", dc, 7);
    chk("lb_wen", wen, 1);

    run_op(3'b101, 1, 0, 4'h0, 32'h2002, 32'h0, 5'd4, 0, 0, 32'hBEEF_1234,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("lhu_wdata", res, 32'h0000_BEEF);
    run_op(3'b010, 1, 0, 4'h0, 32'h2000, 32'h0, 5'd4, 1, 1, 32'hBEEF_1234,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("lw_wdata", res, 32'hBEEF_1234);
    run_op(3'b001, 1, 0, 4'h0, 32'h2000, 32'h0, 5'd6, 0, 0, 32'h0000_8001,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("lh_wdata", res, 32'hFFFF_8001);
    run_op(3'b100, 1, 0, 4'h0, 32'h1001, 32'h0, 5'd6, 0, 0, 32'h1234_8056,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("lbu_wdata", res, 32'h0000_0080);

    // SW, request accepted immediately
    run_op(3'b010, 0, 1, 4'hF, 32'h3008, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0,
           res, wen, fbd, dc, nr, nw, ny, nf, as, ws, ss);
    chk("sw_memwrite_cycles", nw, 1);
    chk("sw_done_cycle", dc, 1);
    chk("sw_wen", wen, 0);
    chk("sw_rd_ready_cycles", ny, 0);
    chk("sw_wdata", ws, 32'hDEAD_BEEF);
    chk("sw_strb", ss, 4'hF);
    chk("sw_address", as, 32'h3008);

    // Reset while waiting for read data
    step();
    complete_pre = 1; mem_info_in = {3'b010, 1'b0, 1'b1, 4'h0};
    mem_address_in = 32'h3000; RF_waddr_in = 5'd7; PC_input = 32'h100;
    step();
    complete_pre = 0; Mem_Req_Ready = 1;
    step();
    Mem_Req_Ready = 0;
    #1 rst = 0;
    #1;
    chk("rstmid_memread", MemRead, 0);
    chk("rstmid_memwrite", MemWrite, 0);
    chk("rstmid_rd_ready", Read_data_Ready, 0);
    chk("rstmid_fb_mem", fb_mem, 0);
    chk("rstmid_complete", complete_this, 0);
    chk("rstmid_wen", RF_wen_out, 0);
    step();
    rst = 1; Read_data_Valid = 1; Read_data = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_valid_no_complete", complete_this, 0);
      step();
    end
    Read_data_Valid = 0;

    // Load followed by ALU op with complete_pre held
    step();
    complete_pre = 1; mem_info_in = {3'b010, 1'b0, 1'b1, 4'h0};
    mem_address_in = 32'h40; RF_waddr_in = 5'd9; PC_input = 32'h200;
    Mem_Req_Ready = 1; Read_data_Valid = 1; Read_data = 32'hCAFE_0001;
    step();
    mem_info_in = 9'h000; Write_data_in = 32'h55; RF_waddr_in = 5'd10; PC_input = 32'h204;
    np = 0; drop = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (complete_this) begin
        if (np < 2) begin pw[np] = RF_wdata_out; pa[np] = RF_waddr_out; pidx[np] = c; end
        np++;
      end
      if (c < 2) chk("b2b_fb_busy", fb_mem, 1);
      if (!fb_mem) drop = 1;
      step();
      if (drop) complete_pre = 0;
    end
    Mem_Req_Ready = 0; Read_data_Valid = 0;
    chk("b2b_pulses", np, 2);
    if (np >= 2) begin
      chk("b2b_first_wdata", pw[0], 32'hCAFE_0001);
      chk("b2b_first_waddr", pa[0], 5'd9);
      chk("b2b_second_wdata", pw[1], 32'h55);
      chk("b2b_second_waddr", pa[1], 5'd10);
      chk("b2b_first_idx", pidx[0], 2);
      chk("b2b_second_idx", pidx[1], 3);
    end

    // Randomized traffic, checked by the model on every cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst) rst = 1;
      complete_pre = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0, 1: mem_info_in = {3'($urandom_range(0, 7)), 1'b0, 1'b0, 4'($urandom)};
        2: begin
          case ($urandom_range(0, 4))
            0: mem_info_in = {3'b000, 1'b0, 1'b1, 4'h0};
            1: mem_info_in = {3'b001, 1'b0, 1'b1, 4'h0};
            2: mem_info_in = {3'b010, 1'b0, 1'b1, 4'h0};
            3: mem_info_in = {3'b100, 1'b0, 1'b1, 4'h0};
            default: mem_info_in = {3'b101, 1'b0, 1'b1, 4'h0};
          endcase
        end
        default: mem_info_in = {3'($urandom_range(0, 2)), 1'b1, 1'b0, 4'($urandom)};
      endcase
      Write_data_in   = $urandom;
      mem_address_in  = $urandom;
      RF_waddr_in     = 5'($urandom);
      PC_input        = $urandom;
      Mem_Req_Ready   = $urandom_range(0, 2) == 0;
      Read_data_Valid = $urandom_range(0, 2) == 0;
      Read_data       = $urandom;
      if ($urandom_range(0, 399) == 0) rst = 0;
    end

    step();
    rst = 1; complete_pre = 0; Mem_Req_Ready = 0; Read_data_Valid = 0;
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
